// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: mul/div FSM
// encoding and the stage indices used to address stall/flush vectors.
package pipeline_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } md_state_e;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters;
// holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_inc && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) count_q <= '0;
    else       count_q <= count_d;
  end

  assign o_count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage core: resolves memory waits,
// mul/div occupancy, branch redirects, load-use and fetch waits by priority.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_hazard_stall,
  input  logic             i_branch_taken_ex,
  input  logic             i_imem_busy,
  input  logic             i_imem_ready,
  input  logic             i_dmem_req_mem,
  input  logic             i_dmem_ready,
  input  logic             i_md_start_ex,
  input  logic             i_md_done,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_stall_ex,
  output logic             o_stall_mem,
  output logic             o_flush_id,
  output logic             o_flush_ex,
  output logic             o_flush_mem,
  output logic             o_flush_wb,
  output logic             o_fetch_kill,
  output logic             o_md_busy,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  md_state_e                state_q, state_d;
  logic                     kill_q, kill_d;
  logic [STG_MEM:STG_IF]    stall;
  logic [STG_WB:STG_ID]     flush;
  logic                     redirect_acc;
  logic                     dmem_wait, md_wait, fetch_wait;

  // First matching condition wins; a branch only counts as accepted when no
  // memory or mul/div wait is holding EX.
  always_comb begin
    dmem_wait    = i_dmem_req_mem & ~i_dmem_ready;
    md_wait      = ((state_q == MD_WAIT) | i_md_start_ex) & ~i_md_done;
    fetch_wait   = (i_imem_busy & ~i_imem_ready) | kill_q;
    stall        = '0;
    flush        = '0;
    redirect_acc = 1'b0;
    if (i_rst) begin
      flush = '1;
    end else if (dmem_wait) begin
      stall         = '1;
      flush[STG_WB] = 1'b1;
    end else if (md_wait) begin
      stall[STG_IF]  = 1'b1;
      stall[STG_ID]  = 1'b1;
      stall[STG_EX]  = 1'b1;
      flush[STG_MEM] = 1'b1;
    end else if (i_branch_taken_ex) begin
      flush[STG_ID] = 1'b1;
      flush[STG_EX] = 1'b1;
      redirect_acc  = 1'b1;
    end else if (i_hazard_stall) begin
      stall[STG_IF] = 1'b1;
      stall[STG_ID] = 1'b1;
      flush[STG_EX] = 1'b1;
    end else if (fetch_wait) begin
      stall[STG_IF] = 1'b1;
      flush[STG_ID] = 1'b1;
    end
  end

  // A response arriving in the redirect cycle is already dropped by the ID
  // flush, so the kill flag only arms while the fetch is still in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (i_md_start_ex && !i_md_done) state_d = MD_WAIT;
      MD_WAIT: if (i_md_done) state_d = RUN;
      default: state_d = RUN;
    endcase
    kill_d = kill_q;
    if (i_imem_ready)                     kill_d = 1'b0;
    else if (redirect_acc && i_imem_busy) kill_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RUN;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (stall[STG_IF]),
    .o_count (o_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (redirect_acc),
    .o_count (o_flush_cnt)
  );

  assign o_stall_if   = stall[STG_IF];
  assign o_stall_id   = stall[STG_ID];
  assign o_stall_ex   = stall[STG_EX];
  assign o_stall_mem  = stall[STG_MEM];
  assign o_flush_id   = flush[STG_ID];
  assign o_flush_ex   = flush[STG_EX];
  assign o_flush_mem  = flush[STG_MEM];
  assign o_flush_wb   = flush[STG_WB];
  assign o_fetch_kill = kill_q & ~i_rst;
  assign o_md_busy    = (state_q == MD_WAIT) & ~i_rst;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: vector table, directed multi-cycle sequences and
// random stimulus against a priority-list reference model (CNT_W=4 and 32).
module tb_pipeline_ctrl;

  localparam logic [8:0] RST = 9'h100, HZ = 9'h080, BR = 9'h040, IB = 9'h020,
                         IR = 9'h010, DRQ = 9'h008, DRDY = 9'h004,
                         MDS = 9'h002, MDD = 9'h001, NONE = 9'h000;

  // Ordered conditions: dmem, mul/div, redirect, load-use, fetch.
  // Stall bits {if,id,ex,mem}; flush bits {id,ex,mem,wb}.
  localparam logic [3:0] ST_M [0:4] = '{4'b1111, 4'b1110, 4'b0000, 4'b1100, 4'b1000};
  localparam logic [3:0] FL_M [0:4] = '{4'b0001, 4'b0010, 4'b1100, 4'b0100, 4'b1000};

  typedef struct {
    logic [8:0] in;
    logic [3:0] st;
    logic [3:0] fl;
  } vec_t;

  logic clk = 1'b0;
  logic rst, hz, br, ib, ir, dreq, drdy, mds, mdd;
  logic [3:0]  a_st, a_fl, b_st, b_fl;
  logic        a_kill, a_busy, b_kill, b_busy;
  logic [3:0]  a_sc, a_fc;
  logic [31:0] b_sc, b_fc;

  int errors = 0;
  int checks = 0;

  bit     m_md, m_kill;
  longint m_sc4, m_fc4, m_sc32, m_fc32;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_hazard_stall(hz), .i_branch_taken_ex(br),
    .i_imem_busy(ib), .i_imem_ready(ir), .i_dmem_req_mem(dreq),
    .i_dmem_ready(drdy), .i_md_start_ex(mds), .i_md_done(mdd),
    .o_stall_if(a_st[3]), .o_stall_id(a_st[2]), .o_stall_ex(a_st[1]),
    .o_stall_mem(a_st[0]), .o_flush_id(a_fl[3]), .o_flush_ex(a_fl[2]),
    .o_flush_mem(a_fl[1]), .o_flush_wb(a_fl[0]), .o_fetch_kill(a_kill),
    .o_md_busy(a_busy), .o_stall_cnt(a_sc), .o_flush_cnt(a_fc)
  );

  pipeline_ctrl #(.CNT_W(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_hazard_stall(hz), .i_branch_taken_ex(br),
    .i_imem_busy(ib), .i_imem_ready(ir), .i_dmem_req_mem(dreq),
    .i_dmem_ready(drdy), .i_md_start_ex(mds), .i_md_done(mdd),
    .o_stall_if(b_st[3]), .o_stall_id(b_st[2]), .o_stall_ex(b_st[1]),
    .o_stall_mem(b_st[0]), .o_flush_id(b_fl[3]), .o_flush_ex(b_fl[2]),
    .o_flush_mem(b_fl[1]), .o_flush_wb(b_fl[0]), .o_fetch_kill(b_kill),
    .o_md_busy(b_busy), .o_stall_cnt(b_sc), .o_flush_cnt(b_fc)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic [8:0] v);
    {rst, hz, br, ib, ir, dreq, drdy, mds, mdd} = v;
  endtask

  function automatic longint sat(input longint v, input longint max);
    return (v > max) ? max : v;
  endfunction

  // Reference outputs: scan the condition list, first active one decides.
  function automatic void model_out(output logic [3:0] st, output logic [3:0] fl,
                                    output logic kill, output logic busy,
                                    output bit acc);
    bit active [0:4];
    int first;
    active[0] = dreq && !drdy;
    active[1] = (m_md || mds) && !mdd;
    active[2] = br;
    active[3] = hz;
    active[4] = (ib && !ir) || m_kill;
    first = -1;
    for (int i = 0; i < 5; i++)
      if (active[i] && first < 0) first = i;
    st = 4'b0000; fl = 4'b0000; kill = 1'b0; busy = 1'b0; acc = 1'b0;
    if (rst) begin
      fl = 4'b1111;
    end else begin
      if (first >= 0) begin
        st = ST_M[first];
        fl = FL_M[first];
      end
      kill = m_kill;
      busy = m_md;
      acc  = (first == 2);
    end
  endfunction

  function automatic void model_step(input logic stall_if, input bit acc);
    if (rst) begin
      m_md = 0; m_kill = 0;
      m_sc4 = 0; m_fc4 = 0; m_sc32 = 0; m_fc32 = 0;
    end else begin
      m_sc4  = sat(m_sc4 + stall_if, 15);
      m_sc32 = sat(m_sc32 + stall_if, 64'hFFFF_FFFF);
      m_fc4  = sat(m_fc4 + acc, 15);
      m_fc32 = sat(m_fc32 + acc, 64'hFFFF_FFFF);
      if (ir)             m_kill = 0;
      else if (acc && ib) m_kill = 1;
      if (m_md) m_md = !mdd;
      else      m_md = mds && !mdd;
    end
  endfunction

  task automatic tick(input bit use_tbl = 0, input logic [3:0] est = '0,
                      input logic [3:0] efl = '0);
    logic [3:0] st, fl;
    logic k, b;
    bit acc;
    @(negedge clk);
    model_out(st, fl, k, b, acc);
    if (use_tbl) begin
      check("tbl_stall", a_st, est);
      check("tbl_flush", a_fl, efl);
    end
    check("outs_w4",  {a_st, a_fl, a_kill, a_busy}, {st, fl, k, b});
    check("outs_w32", {b_st, b_fl, b_kill, b_busy}, {st, fl, k, b});
    check("stall_cnt_w4",  a_sc, m_sc4);
    check("flush_cnt_w4",  a_fc, m_fc4);
    check("stall_cnt_w32", b_sc, m_sc32);
    check("flush_cnt_w32", b_fc, m_fc32);
    @(posedge clk);
    model_step(st[3], acc);
    #1;
  endtask

  task automatic do_reset();
    apply(RST);
    tick();
    apply(NONE);
  endtask

  vec_t tbl [$];
  int   nb;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    m_md = 0; m_kill = 0; m_sc4 = 0; m_fc4 = 0; m_sc32 = 0; m_fc32 = 0;
    apply(RST);
    tick(1, 4'b0000, 4'b1111);
    tick();

    tbl.push_back('{NONE,             4'b0000, 4'b0000});
    tbl.push_back('{HZ,               4'b1100, 4'b0100});
    tbl.push_back('{BR | HZ,          4'b0000, 4'b1100});
    tbl.push_back('{DRQ | BR,         4'b1111, 4'b0001});
    tbl.push_back('{DRQ | DRDY | HZ,  4'b1100, 4'b0100});
    tbl.push_back('{MDS,              4'b1110, 4'b0010});
    tbl.push_back('{MDS | MDD,        4'b0000, 4'b0000});
    tbl.push_back('{MDD,              4'b0000, 4'b0000});
    tbl.push_back('{IB,               4'b1000, 4'b1000});
    tbl.push_back('{IB | IR,          4'b0000, 4'b0000});
    tbl.push_back('{RST | HZ | BR,    4'b0000, 4'b1111});
    tbl.push_back('{MDS | HZ | BR | IB, 4'b1110, 4'b0010});
    tbl.push_back('{DRQ | MDS,        4'b1111, 4'b0001});
    foreach (tbl[i]) begin
      apply(tbl[i].in);
      tick(1, tbl[i].st, tbl[i].fl);
      do_reset();
    end

    // Load-use then branch-over-load-use counter effects
    apply(HZ); tick();
    check("loaduse_scnt", a_sc, 1);
    apply(BR | HZ); tick();
    check("branch_fcnt", a_fc, 1);
    do_reset();

    // Mul/div: start, done four cycles later
    apply(MDS); tick();
    nb = 0;
    for (int k = 0; k < 4; k++) begin
      if (a_busy) nb++;
      apply(k == 3 ? MDD : NONE);
      tick();
    end
    check("md_busy_cycles", nb, 4);
    check("md_back_run", a_busy, 0);
    apply(NONE); tick();

    // Dmem wait holds a branch for three cycles
    do_reset();
    for (int k = 0; k < 3; k++) begin
      apply(DRQ | BR); tick();
    end
    check("dmem_fcnt_hold", a_fc, 0);
    apply(BR); tick();
    check("dmem_fcnt_accept", a_fc, 1);

    // Fetch kill across a redirect with a slow fetch
    do_reset();
    apply(BR | IB); tick();
    check("kill_set", a_kill, 1);
    apply(IB); tick();
    apply(IB); tick();
    check("kill_hold", a_kill, 1);
    apply(IR); tick();
    check("kill_clr", a_kill, 0);
    apply(NONE); tick();

    // Redirect coinciding with the fetch response does not arm the kill
    apply(BR | IB | IR); tick();
    check("kill_same_cycle", a_kill, 0);

    // Reset in the middle of MD_WAIT, then a stray done
    do_reset();
    apply(MDS); tick();
    apply(HZ); tick();
    apply(RST); tick();
    apply(NONE);
    check("rst_md_busy", a_busy, 0);
    check("rst_md_scnt", a_sc, 0);
    apply(MDD); tick();
    check("late_done_busy", a_busy, 0);

    // Saturation of the narrow counter
    do_reset();
    for (int k = 0; k < 20; k++) begin
      apply(HZ); tick();
    end
    check("sat_w4", a_sc, 15);
    check("nosat_w32", b_sc, 20);

    // Random stimulus against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [8:0] v;
      v[8] = ($urandom_range(63) == 0);
      v[7] = ($urandom_range(3) == 0);
      v[6] = ($urandom_range(3) == 0);
      v[5] = ($urandom_range(1) == 0);
      v[4] = ($urandom_range(2) == 0);
      v[3] = ($urandom_range(3) == 0);
      v[2] = ($urandom_range(1) == 0);
      v[1] = ($urandom_range(5) == 0);
      v[0] = ($urandom_range(4) == 0);
      apply(v);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
